disp_scan_mux: RTL

//   Upstream feeder for the 4-bit binary-to-7-segment decoder on the DPWM board display.

---
 rtl/dpwm_disp_pkg.sv | 28 ++
 rtl/bin2bcd_seq.sv | 63 ++++++
 rtl/disp_scan_mux.sv | 113 +++++++++++
 3 files changed

// File: rtl/dpwm_disp_pkg.sv
// Shared constants, FSM state type and BCD helper for the DPWM board display feeder.
package dpwm_disp_pkg;

  localparam int N_DIGITS = 4;
  localparam int BIN_W    = 14;
  localparam int BCD_W    = 4 * N_DIGITS;

  localparam logic [BIN_W-1:0]    MAX_VAL    = 14'd9999;
  localparam logic [N_DIGITS-1:0] AN_OFF     = 4'b1111;
  localparam logic [3:0]          SHIFT_LAST = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Double-dabble correction: nibbles of 5 or more get +3 before the next shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one input bit per clock, 14 clocks per value.
module bin2bcd_seq
  import dpwm_disp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t      r_state;
  conv_state_t      w_next;
  logic [BIN_W-1:0] r_shift;
  logic [BCD_W-1:0] r_bcd;
  logic [3:0]       r_cnt;
  logic [BCD_W-1:0] w_adj;

  assign w_adj = add3_nibbles(r_bcd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_shift <= (value > MAX_VAL) ? MAX_VAL : value;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          {r_bcd, r_shift} <= {w_adj[BCD_W-2:0], r_shift, 1'b0};
          r_cnt            <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load) w_next = SHIFT;
      SHIFT:   if (r_cnt == SHIFT_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // DONE is the commit cycle; the top registers it into its own done pulse.
  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign bcd  = r_bcd;

endmodule

// File: rtl/disp_scan_mux.sv
// Converts a 14-bit value to BCD and time-multiplexes the four digits onto an active-low
// anode bus plus a 4-bit digit code for the downstream 7-segment decoder.
module disp_scan_mux
  import dpwm_disp_pkg::*;
#(
  parameter int DIV_BITS = 18,
  parameter int BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [BIN_W-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic                bcd_valid,
  output logic                ovf,
  output logic [3:0]          bin,
  output logic [N_DIGITS-1:0] an
);

  logic                w_busy;
  logic                w_commit;
  logic [BCD_W-1:0]    w_bcd;
  logic                w_accept;
  logic                w_wrap;
  logic [N_DIGITS-1:0] w_blank;
  logic [3:0]          w_digit;
  logic                w_zero_above;

  logic [DIV_BITS-1:0] r_refresh;
  logic [1:0]          r_idx;
  logic [BCD_W-1:0]    r_disp;
  logic                r_done;
  logic                r_bcd_valid;
  logic                r_ovf;
  logic [3:0]          r_bin;
  logic [N_DIGITS-1:0] r_an;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .value (value),
    .busy  (w_busy),
    .done  (w_commit),
    .bcd   (w_bcd)
  );

  // Loads are only taken in IDLE; the converter drops them in SHIFT and DONE as well.
  assign w_accept = load & ~w_busy & ~w_commit;
  assign w_wrap   = &r_refresh;

  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    if (!r_bcd_valid) begin
      w_blank = '1;
    end else if (BLANK_LZ != 0) begin
      for (int i = N_DIGITS - 1; i > 0; i--) begin
        w_zero_above = w_zero_above & (r_disp[4*i +: 4] == 4'd0);
        w_blank[i]   = w_zero_above;
      end
    end
  end

  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      2'd0: w_digit = r_disp[3:0];
      2'd1: w_digit = r_disp[7:4];
      2'd2: w_digit = r_disp[11:8];
      2'd3: w_digit = r_disp[15:12];
      default: w_digit = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh   <= '0;
      r_idx       <= '0;
      r_disp      <= '0;
      r_done      <= 1'b0;
      r_bcd_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_bin       <= '0;
      r_an        <= AN_OFF;
    end else begin
      r_refresh <= r_refresh + {{(DIV_BITS-1){1'b0}}, 1'b1};
      r_idx     <= r_idx + {1'b0, w_wrap};
      r_done    <= w_commit;
      if (w_accept) r_ovf <= (value > MAX_VAL);
      if (w_commit) begin
        r_disp      <= w_bcd;
        r_bcd_valid <= 1'b1;
      end
      if (w_blank[r_idx]) begin
        r_an  <= AN_OFF;
        r_bin <= 4'd0;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_bin <= w_digit;
      end
    end
  end

  assign busy      = w_busy;
  assign done      = r_done;
  assign bcd_valid = r_bcd_valid;
  assign ovf       = r_ovf;
  assign bin       = r_bin;
  assign an        = r_an;

endmodule
